// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target: FSM encoding, bus constants
// and the default glitch-filter length.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ID    = 4'd1,
    ST_ACK_ID    = 4'd2,
    ST_SUB_ADDR  = 4'd3,
    ST_ACK_SUB   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_ACK_DATA  = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_NA     = 4'd8,
    ST_WAIT_STOP = 4'd9
  } sccb_tgt_state_t;

  localparam logic        SCCB_ACK       = 1'b0;
  localparam logic [3:0]  SCCB_BYTE_BITS = 4'd8;
  localparam int unsigned SCCB_FILT_LEN  = 3;

  function automatic logic is_ack_state(input sccb_tgt_state_t s);
    return (s == ST_ACK_ID) || (s == ST_ACK_SUB) || (s == ST_ACK_DATA);
  endfunction

endpackage

// File: rtl/sccb_line_filter.sv
// One bus line: 2-FF synchronizer, FILT_LEN-sample glitch filter, edge detect.
// o_q, o_rise and o_fall update together, 2+FILT_LEN cycles after the pad.
module sccb_line_filter
  import sccb_pkg::*;
#(
  parameter int unsigned FILT_LEN = SCCB_FILT_LEN
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The filtered level only moves after FILT_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  // Lines idle high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= i_d;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_q    = filt_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/sccb_target.sv
// SCCB target: decodes 3-phase writes and 2-phase write + 2-phase read on
// oversampled SIOC/SIOD and presents them on a parallel register port.
module sccb_target
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_F    = 100_000_000,
  parameter int unsigned SCCB_F   = 400_000,
  parameter logic [7:0]  DEV_ID   = 8'h42,
  parameter int unsigned FILT_LEN = SCCB_FILT_LEN
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_sioc,
  input  logic       i_siod,
  output logic       o_siod_oe,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (i_sioc),
    .o_q    (scl_q),
    .o_rise (scl_rise),
    .o_fall (scl_fall)
  );

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (i_siod),
    .o_q    (sda_q),
    .o_rise (sda_rise),
    .o_fall (sda_fall)
  );

  sccb_tgt_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       is_rd_q, is_rd_d;
  logic       pend_q, pend_d;
  logic       oe_q, oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       err_q, err_d;

  logic       start, stop, ack_st, mid_byte, last_bit;
  logic [7:0] rx_byte;
  logic [2:0] rd_bit_idx;

  // SIOC edge is taken as happening first, so its post-edge level qualifies SIOD edges.
  assign start = sda_fall & scl_q;
  assign stop  = sda_rise & scl_q;

  // pend_q marks an SCL high period whose bit may still turn into a START/STOP;
  // that bit does not make the byte "started".
  assign mid_byte   = bit_cnt_q > {3'b000, pend_q};
  assign ack_st     = is_ack_state(state_q);
  assign last_bit   = bit_cnt_q == (SCCB_BYTE_BITS - 4'd1);
  assign rx_byte    = {sr_q[6:0], sda_q};
  assign rd_bit_idx = 3'(SCCB_BYTE_BITS - 4'd1 - bit_cnt_q);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    is_rd_d   = is_rd_q;
    pend_d    = pend_q;
    oe_d      = oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;

    if (scl_rise) begin
      pend_d = 1'b1;
    end else if (scl_fall) begin
      pend_d = 1'b0;
    end

    if (start) begin
      err_d     = mid_byte | ack_st;
      state_d   = ST_DEV_ID;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      pend_d    = 1'b0;
    end else if (stop) begin
      err_d     = mid_byte & ~ack_st;
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      pend_d    = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ID, ST_SUB_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            sr_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              if (state_q == ST_DEV_ID) begin
                if (rx_byte == DEV_ID) begin
                  is_rd_d = 1'b0;
                  state_d = ST_ACK_ID;
                end else if (rx_byte == RD_ID) begin
                  is_rd_d = 1'b1;
                  state_d = ST_ACK_ID;
                end else begin
                  err_d     = 1'b1;
                  state_d   = ST_WAIT_STOP;
                  bit_cnt_d = '0;
                end
              end else if (state_q == ST_SUB_ADDR) begin
                rd_addr_d = rx_byte;
                state_d   = ST_ACK_SUB;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = rd_addr_q;
                wr_data_d = rx_byte;
                state_d   = ST_ACK_DATA;
              end
            end
          end
        end

        // First fall opens the ACK slot, the second one closes it.
        ST_ACK_ID, ST_ACK_SUB, ST_ACK_DATA: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = ~SCCB_ACK;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ACK_ID) begin
                if (is_rd_q) begin
                  state_d   = ST_RD_DATA;
                  rd_data_d = i_rd_data;
                  oe_d      = ~i_rd_data[7];
                  bit_cnt_d = 4'd1;
                end else begin
                  state_d = ST_SUB_ADDR;
                end
              end else if (state_q == ST_ACK_SUB) begin
                state_d = ST_WR_DATA;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        // bit_cnt_q counts bits already presented on the bus.
        ST_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == SCCB_BYTE_BITS) begin
              oe_d      = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RD_NA;
            end else begin
              oe_d      = ~rd_data_q[rd_bit_idx];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_RD_NA: begin
          if (scl_rise) begin
            state_d = ST_WAIT_STOP;
          end
        end

        ST_WAIT_STOP: begin
          oe_d = 1'b0;
        end

        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          oe_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      is_rd_q   <= 1'b0;
      pend_q    <= 1'b0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      is_rd_q   <= is_rd_d;
      pend_q    <= pend_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // Oversampling needs at least 16 system clocks per bus bit.
  assert property (@(posedge i_clk) disable iff (!i_rstn) CLK_F >= 16 * SCCB_F);

  assign o_siod_oe = oe_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_rd_addr = rd_addr_q;
  assign o_busy    = state_q != ST_IDLE;
  assign o_err     = err_q;

endmodule
